// File: rtl/execute_stage_cu.sv
// Decode->Execute control pipeline register with Execute-stage branch/jump resolution.
// Optional branch statistics counters enabled by defining EXECUTE_CU_BRANCH_STATS_EN.
module execute_stage_cu (
  input  logic        clk,
  input  logic        reset,
  input  logic        FlushE,
  input  logic        StallE,
  input  logic        RegWriteD,
  input  logic [2:0]  ResultSrcD,
  input  logic [2:0]  DextControlD,
  input  logic        MemWriteD,
  input  logic        JumpD,
  input  logic        JalrD,
  input  logic        BranchD,
  input  logic [2:0]  BranchTypeD,
  input  logic [3:0]  ALUControlD,
  input  logic        ALUSrcD,
  input  logic        ZeroE,
  input  logic        LtE,
  input  logic        LtuE,
  output logic        RegWriteE,
  output logic [2:0]  ResultSrcE,
  output logic [2:0]  DextControlE,
  output logic        MemWriteE,
  output logic [3:0]  ALUControlE,
  output logic        ALUSrcE,
`ifdef EXECUTE_CU_BRANCH_STATS_EN
  output logic [31:0] BranchCountE,
  output logic [31:0] TakenCountE,
`endif
  output logic        ValidE,
  output logic        BranchTakenE,
  output logic [1:0]  PCSrcE
);

  typedef enum logic [2:0] {
    BR_BEQ  = 3'b000,
    BR_BNE  = 3'b001,
    BR_BLT  = 3'b100,
    BR_BGE  = 3'b101,
    BR_BLTU = 3'b110,
    BR_BGEU = 3'b111
  } br_type_e;

  typedef enum logic [1:0] {
    PC_PLUS4  = 2'b00,
    PC_TARGET = 2'b01,
    PC_ALU    = 2'b10
  } pcsrc_e;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic [2:0] result_src;
    logic [2:0] dext;
    logic       mem_write;
    logic       jump;
    logic       jalr;
    logic       branch;
    br_type_e   br_type;
    logic [3:0] alu_ctrl;
    logic       alu_src;
  } ctrl_t;

  ctrl_t  ctrl_q, ctrl_d;
  logic   cond;
  pcsrc_e pcsrc;

  // Flush beats stall so a redirect always clears a held slot.
  always_comb begin
    ctrl_d = ctrl_q;
    if (FlushE) begin
      ctrl_d = '0;
    end else if (!StallE) begin
      ctrl_d.valid      = 1'b1;
      ctrl_d.reg_write  = RegWriteD;
      ctrl_d.result_src = ResultSrcD;
      ctrl_d.dext       = DextControlD;
      ctrl_d.mem_write  = MemWriteD;
      ctrl_d.jump       = JumpD;
      ctrl_d.jalr       = JalrD;
      ctrl_d.branch     = BranchD;
      ctrl_d.br_type    = br_type_e'(BranchTypeD);
      ctrl_d.alu_ctrl   = ALUControlD;
      ctrl_d.alu_src    = ALUSrcD;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q <= '0;
    end else begin
      ctrl_q <= ctrl_d;
    end
  end

  always_comb begin
    cond = 1'b0;
    case (ctrl_q.br_type)
      BR_BEQ:  cond = ZeroE;
      BR_BNE:  cond = !ZeroE;
      BR_BLT:  cond = LtE;
      BR_BGE:  cond = !LtE;
      BR_BLTU: cond = LtuE;
      BR_BGEU: cond = !LtuE;
      default: cond = 1'b0;
    endcase
  end

  assign BranchTakenE = ctrl_q.valid & ctrl_q.branch & cond;

  // Jump is checked first so an illegal jump+branch decode resolves as the jump.
  always_comb begin
    pcsrc = PC_PLUS4;
    if (ctrl_q.valid && ctrl_q.jump) begin
      pcsrc = ctrl_q.jalr ? PC_ALU : PC_TARGET;
    end else if (BranchTakenE) begin
      pcsrc = PC_TARGET;
    end
  end

  assign PCSrcE       = pcsrc;
  assign ValidE       = ctrl_q.valid;
  assign RegWriteE    = ctrl_q.reg_write;
  assign ResultSrcE   = ctrl_q.result_src;
  assign DextControlE = ctrl_q.dext;
  assign MemWriteE    = ctrl_q.mem_write;
  assign ALUControlE  = ctrl_q.alu_ctrl;
  assign ALUSrcE      = ctrl_q.alu_src;

`ifdef EXECUTE_CU_BRANCH_STATS_EN
  logic [31:0] bcnt_q, bcnt_d;
  logic [31:0] tcnt_q, tcnt_d;
  logic        retire;

  // Counted when the branch leaves E, so stall cycles never double-count.
  assign retire = ctrl_q.valid & ctrl_q.branch & ~StallE & ~FlushE;

  always_comb begin
    bcnt_d = bcnt_q;
    tcnt_d = tcnt_q;
    if (retire) begin
      bcnt_d = bcnt_q + 32'd1;
      if (BranchTakenE) begin
        tcnt_d = tcnt_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bcnt_q <= '0;
      tcnt_q <= '0;
    end else begin
      bcnt_q <= bcnt_d;
      tcnt_q <= tcnt_d;
    end
  end

  assign BranchCountE = bcnt_q;
  assign TakenCountE  = tcnt_q;
`endif

endmodule

// File: tb/tb_execute_stage_cu.sv
// Randomized self-checking bench for execute_stage_cu against a behavioural model.
// Stats counters are checked when EXECUTE_CU_BRANCH_STATS_EN is defined.
module tb_execute_stage_cu;

  logic        clk;
  logic        reset;
  logic        FlushE, StallE;
  logic        RegWriteD, MemWriteD, JumpD, JalrD, BranchD, ALUSrcD;
  logic [2:0]  ResultSrcD, DextControlD, BranchTypeD;
  logic [3:0]  ALUControlD;
  logic        ZeroE, LtE, LtuE;
  logic        RegWriteE, MemWriteE, ALUSrcE, ValidE, BranchTakenE;
  logic [2:0]  ResultSrcE, DextControlE;
  logic [3:0]  ALUControlE;
  logic [1:0]  PCSrcE;
`ifdef EXECUTE_CU_BRANCH_STATS_EN
  logic [31:0] BranchCountE, TakenCountE;
`endif

  execute_stage_cu dut (
    .clk(clk), .reset(reset), .FlushE(FlushE), .StallE(StallE),
    .RegWriteD(RegWriteD), .ResultSrcD(ResultSrcD), .DextControlD(DextControlD),
    .MemWriteD(MemWriteD), .JumpD(JumpD), .JalrD(JalrD), .BranchD(BranchD),
    .BranchTypeD(BranchTypeD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
    .ZeroE(ZeroE), .LtE(LtE), .LtuE(LtuE),
    .RegWriteE(RegWriteE), .ResultSrcE(ResultSrcE), .DextControlE(DextControlE),
    .MemWriteE(MemWriteE), .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE),
`ifdef EXECUTE_CU_BRANCH_STATS_EN
    .BranchCountE(BranchCountE), .TakenCountE(TakenCountE),
`endif
    .ValidE(ValidE), .BranchTakenE(BranchTakenE), .PCSrcE(PCSrcE)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Model of the Execute slot: one record of what was last accepted.
  logic        m_valid, m_rw, m_mw, m_jump, m_jalr, m_br, m_as;
  logic [2:0]  m_rs, m_dx, m_bt;
  logic [3:0]  m_alu;
  logic [31:0] m_bcnt, m_tcnt;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Condition = chosen flag (Zero / Lt / Ltu by the upper two funct3 bits), inverted by bit 0.
  function automatic logic exp_taken();
    logic flag;
    if (!(m_valid && m_br)) return 1'b0;
    case (m_bt[2:1])
      2'b00:   flag = ZeroE;
      2'b10:   flag = LtE;
      2'b11:   flag = LtuE;
      default: return 1'b0;
    endcase
    return flag ^ m_bt[0];
  endfunction

  function automatic logic [1:0] exp_pcsrc();
    if (!m_valid) return 2'd0;
    if (m_jump) return m_jalr ? 2'd2 : 2'd1;
    return exp_taken() ? 2'd1 : 2'd0;
  endfunction

  task automatic model_clear();
    {m_valid, m_rw, m_mw, m_jump, m_jalr, m_br, m_as} = '0;
    {m_rs, m_dx, m_bt, m_alu} = '0;
    m_bcnt = '0;
    m_tcnt = '0;
  endtask

  task automatic model_edge();
    if (m_valid && m_br && !StallE && !FlushE) begin
      m_bcnt = m_bcnt + 1;
      if (exp_taken()) m_tcnt = m_tcnt + 1;
    end
    if (FlushE) begin
      {m_valid, m_rw, m_mw, m_jump, m_jalr, m_br, m_as} = '0;
      {m_rs, m_dx, m_bt, m_alu} = '0;
    end else if (!StallE) begin
      m_valid = 1'b1;
      m_rw = RegWriteD;   m_rs = ResultSrcD;  m_dx = DextControlD;
      m_mw = MemWriteD;   m_jump = JumpD;     m_jalr = JalrD;
      m_br = BranchD;     m_bt = BranchTypeD; m_alu = ALUControlD;
      m_as = ALUSrcD;
    end
  endtask

  task automatic compare_all();
    check("ValidE", 32'(ValidE), 32'(m_valid));
    check("RegWriteE", 32'(RegWriteE), 32'(m_rw));
    check("ResultSrcE", 32'(ResultSrcE), 32'(m_rs));
    check("DextControlE", 32'(DextControlE), 32'(m_dx));
    check("MemWriteE", 32'(MemWriteE), 32'(m_mw));
    check("ALUControlE", 32'(ALUControlE), 32'(m_alu));
    check("ALUSrcE", 32'(ALUSrcE), 32'(m_as));
    check("BranchTakenE", 32'(BranchTakenE), 32'(exp_taken()));
    check("PCSrcE", 32'(PCSrcE), 32'(exp_pcsrc()));
`ifdef EXECUTE_CU_BRANCH_STATS_EN
    check("BranchCountE", BranchCountE, m_bcnt);
    check("TakenCountE", TakenCountE, m_tcnt);
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic set_idle();
    {FlushE, StallE, RegWriteD, MemWriteD, JumpD, JalrD, BranchD, ALUSrcD} = '0;
    {ResultSrcD, DextControlD, BranchTypeD, ALUControlD} = '0;
    {ZeroE, LtE, LtuE} = '0;
  endtask

  task automatic rand_inputs();
    RegWriteD    = 1'($urandom);
    ResultSrcD   = 3'($urandom);
    DextControlD = 3'($urandom);
    MemWriteD    = 1'($urandom);
    JumpD        = ($urandom_range(0, 5) == 0);
    JalrD        = 1'($urandom);
    BranchD      = ($urandom_range(0, 2) == 0);
    BranchTypeD  = 3'($urandom);
    ALUControlD  = 4'($urandom);
    ALUSrcD      = 1'($urandom);
    ZeroE        = 1'($urandom);
    LtE          = 1'($urandom);
    LtuE         = 1'($urandom);
    FlushE       = ($urandom_range(0, 7) == 0);
    StallE       = ($urandom_range(0, 3) == 0);
  endtask

  // Reset pulse placed strictly between edges; outputs must clear without a clock.
  task automatic async_reset_pulse();
    #1 reset = 1'b0;
    #1;
    model_clear();
    check("async_rst ValidE", 32'(ValidE), 32'd0);
    check("async_rst PCSrcE", 32'(PCSrcE), 32'd0);
    compare_all();
    #1 reset = 1'b1;
  endtask

  logic [7:0] taken_mask [7];
  logic [2:0] br_types   [7];

  initial begin
    br_types   = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010};
    // Bit index = {LtuE, LtE, ZeroE}.
    taken_mask = '{8'hAA, 8'h55, 8'hCC, 8'h33, 8'hF0, 8'h0F, 8'h00};

    // Reset with arbitrary inputs.
    reset = 1'b0;
    rand_inputs();
    JumpD = 1'b1; JalrD = 1'b1; BranchD = 1'b1;
    model_clear();
    @(negedge clk);
    @(negedge clk);
    check("rst ValidE", 32'(ValidE), 32'd0);
    check("rst PCSrcE", 32'(PCSrcE), 32'd0);
    check("rst RegWriteE", 32'(RegWriteE), 32'd0);
    compare_all();

    // First load after reset.
    reset = 1'b1;
    set_idle();
    RegWriteD = 1'b1; ResultSrcD = 3'b010;
    step();
    check("load RegWriteE", 32'(RegWriteE), 32'd1);
    check("load ResultSrcE", 32'(ResultSrcE), 32'd2);
    check("load ValidE", 32'(ValidE), 32'd1);

    // Stall holds, flush beats stall.
    set_idle();
    MemWriteD = 1'b1;
    step();
    MemWriteD = 1'b0; StallE = 1'b1;
    step();
    check("stall MemWriteE", 32'(MemWriteE), 32'd1);
    FlushE = 1'b1;
    step();
    check("flush+stall MemWriteE", 32'(MemWriteE), 32'd0);
    check("flush+stall ValidE", 32'(ValidE), 32'd0);

    // Branch matrix: hold the branch in E, sweep the flags combinationally.
    for (int t = 0; t < 7; t++) begin
      set_idle();
      BranchD = 1'b1; BranchTypeD = br_types[t];
      step();
      StallE = 1'b1;
      for (int f = 0; f < 8; f++) begin
        {LtuE, LtE, ZeroE} = 3'(f);
        #1;
        check($sformatf("br t%0d f%0d PCSrcE", t, f), 32'(PCSrcE), taken_mask[t][f] ? 32'd1 : 32'd0);
        check($sformatf("br t%0d f%0d taken", t, f), 32'(BranchTakenE), 32'(taken_mask[t][f]));
      end
      step();
    end

    // Jumps, then bubble.
    set_idle();
    JumpD = 1'b1;
    step();
    check("jal PCSrcE", 32'(PCSrcE), 32'd1);
    JalrD = 1'b1; BranchD = 1'b1; BranchTypeD = 3'b010;
    step();
    check("jalr PCSrcE", 32'(PCSrcE), 32'd2);
    FlushE = 1'b1;
    step();
    check("jalr flushed PCSrcE", 32'(PCSrcE), 32'd0);

    // Async reset while a JALR is stalled in E.
    set_idle();
    JumpD = 1'b1; JalrD = 1'b1;
    step();
    StallE = 1'b1;
    step();
    check("held jalr PCSrcE", 32'(PCSrcE), 32'd2);
    async_reset_pulse();
    set_idle();
    step();

`ifdef EXECUTE_CU_BRANCH_STATS_EN
    // Three BEQs, outcomes taken / not / taken, the middle one stalled two cycles.
    set_idle();
    async_reset_pulse();
    BranchD = 1'b1;
    step();
    ZeroE = 1'b1;
    step();
    ZeroE = 1'b0; StallE = 1'b1;
    step();
    step();
    StallE = 1'b0;
    step();
    ZeroE = 1'b1; BranchD = 1'b0;
    step();
    set_idle();
    step();
    check("stats BranchCountE", BranchCountE, 32'd3);
    check("stats TakenCountE", TakenCountE, 32'd2);
`endif

    // Random phase with occasional mid-cycle resets.
    for (int i = 0; i < 4000; i++) begin
      rand_inputs();
      if ($urandom_range(0, 199) == 0) async_reset_pulse();
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
